// File: rtl/ro_sched_pkg.sv
// ro_sched_pkg: shared states, defaults and index-width helper for the RO scan scheduler
package ro_sched_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_WARMUP, S_CLEAR, S_MEASURE, S_SETTLE, S_STORE, S_NEXT
  } state_t;
  localparam int WARMUP_DEF = 16;
  localparam int SETTLE_DEF = 4;
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/ro_pick_next.sv
// ro_pick_next: finds the lowest set mask bit at or above ptr
module ro_pick_next import ro_sched_pkg::*; #(
  parameter int NUM_RO = 4,
  parameter int IDX_W = idx_w(NUM_RO)
) (
  input  logic [NUM_RO-1:0] mask,
  input  logic [IDX_W:0]    ptr,
  output logic              found,
  output logic [IDX_W-1:0]  idx
);
  always_comb begin
    found = 1'b0;
    idx = '0;
    for (int i = NUM_RO - 1; i >= 0; i--) begin
      if (mask[i] && (IDX_W + 1)'(i) >= ptr) begin
        found = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end
endmodule

// File: rtl/ro_scan_sched.sv
// ro_scan_sched: time-shares one RO frequency counter across NUM_RO oscillators
module ro_scan_sched import ro_sched_pkg::*; #(
  parameter int NUM_RO = 4,
  parameter int CNT_W = 32,
  parameter int WIN_W = 24,
  parameter int WARMUP_CYC = WARMUP_DEF,
  parameter int SETTLE_CYC = SETTLE_DEF,
  localparam int IDX_W = idx_w(NUM_RO)
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic              start,
  input  logic              stop,
  input  logic              continuous,
  input  logic [NUM_RO-1:0] ro_mask,
  input  logic [WIN_W-1:0]  win_len,
  output logic              busy,
  output logic              done,
  output logic [NUM_RO-1:0] ro_en,
  output logic [IDX_W-1:0]  ro_sel,
  output logic              cnt_clr,
  output logic              cnt_gate,
  input  logic [CNT_W-1:0]  cnt_in,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [IDX_W-1:0]  res_id,
  output logic [CNT_W-1:0]  res_count,
  output logic              res_sat
);
  state_t state, state_n;
  logic [NUM_RO-1:0] mask;
  logic [WIN_W-1:0] win_m1, tmr;
  logic cont, stop_pend, found, finish, tmr_zero;
  logic [IDX_W:0] pick_ptr;
  logic [IDX_W-1:0] pick_idx;

  // NEXT looks strictly above the current RO, SELECT at or above it
  assign pick_ptr = {1'b0, ro_sel} + {{IDX_W{1'b0}}, state == S_NEXT};
  assign tmr_zero = (tmr == '0);
  assign finish = stop_pend | stop | (!found & !cont);

  ro_pick_next #(.NUM_RO(NUM_RO), .IDX_W(IDX_W)) u_pick (
    .mask(mask), .ptr(pick_ptr), .found(found), .idx(pick_idx)
  );

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:    state_n = (start && |ro_mask) ? S_SELECT : S_IDLE;
      S_SELECT:  state_n = S_WARMUP;
      S_WARMUP:  state_n = tmr_zero ? S_CLEAR : S_WARMUP;
      S_CLEAR:   state_n = S_MEASURE;
      S_MEASURE: state_n = tmr_zero ? S_SETTLE : S_MEASURE;
      S_SETTLE:  state_n = tmr_zero ? S_STORE : S_SETTLE;
      S_STORE:   state_n = res_ready ? S_NEXT : S_STORE;
      S_NEXT:    state_n = finish ? S_IDLE : S_SELECT;
      default:   state_n = S_IDLE;
    endcase
  end

  assign ro_en = (state inside {S_WARMUP, S_CLEAR, S_MEASURE, S_SETTLE}) ? NUM_RO'(1) << ro_sel : '0;
  assign cnt_clr = (state == S_CLEAR);
  assign cnt_gate = (state == S_MEASURE);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state <= S_IDLE;
      mask <= '0;
      win_m1 <= '0;
      cont <= 1'b0;
      stop_pend <= 1'b0;
      tmr <= '0;
      ro_sel <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      res_valid <= 1'b0;
      res_id <= '0;
      res_count <= '0;
      res_sat <= 1'b0;
    end else begin
      state <= state_n;
      busy <= (state_n != S_IDLE) || (state == S_NEXT);
      done <= (state == S_IDLE && start && !(|ro_mask)) || (state == S_NEXT && finish);
      stop_pend <= (state_n != S_IDLE) && (stop_pend || (stop && state != S_IDLE));
      if (state == S_IDLE && start) begin
        mask <= ro_mask;
        win_m1 <= (win_len == '0) ? '0 : win_len - WIN_W'(1);
        cont <= continuous;
        ro_sel <= '0;
      end
      if (state == S_SELECT) ro_sel <= pick_idx;
      if (state == S_NEXT) ro_sel <= found ? pick_idx : '0;
      tmr <= (state == S_SELECT) ? WIN_W'(WARMUP_CYC - 1) :
             (state == S_CLEAR) ? win_m1 :
             (state == S_MEASURE && tmr_zero) ? WIN_W'(SETTLE_CYC - 1) :
             tmr_zero ? tmr : tmr - WIN_W'(1);
      if (state == S_SETTLE && tmr_zero) begin
        res_valid <= 1'b1;
        res_id <= ro_sel;
        res_count <= cnt_in;
        res_sat <= &cnt_in;
      end else if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end
endmodule
